// File: rtl/pc_gen_unit.sv
// Program-counter generator for the single-cycle core.
// Picks the next fetch address from sequential/JAL/JALR/branch sources,
// handshakes with instruction memory, traps on misaligned control-flow
// targets and runs a circular return-address stack that flags
// mispredicted returns.
module pc_gen_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'('h100),
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_ready,
  output logic [XLEN-1:0]              pc,
  output logic                         pc_valid,
  output logic [XLEN-1:0]              pc_plus4,
  input  logic [XLEN-1:0]              imm,
  input  logic [XLEN-1:0]              rs1_val,
  input  logic                         branch,
  input  logic                         alu_zero,
  input  logic                         jal,
  input  logic                         jalr,
  input  logic                         is_call,
  input  logic                         is_ret,
  input  logic                         trap_clear,
  output logic                         misalign_trap,
  output logic                         ras_mispredict,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  state_t state, state_next;

  logic             advance;
  logic             take;
  logic             misaligned;
  logic [XLEN-1:0]  jalr_sum;
  logic [XLEN-1:0]  rel_tgt;
  logic [XLEN-1:0]  tgt;

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr, ptr_next;
  logic [CNT_W-1:0] cnt_next;
  logic [XLEN-1:0]  ras_top;
  logic             do_push;
  logic             do_pop;
  logic             pop_miss;

  // Link value and fetch-valid flag derived directly from registered state.
  assign pc_plus4 = pc + XLEN'(4);
  assign pc_valid = (state == ST_RUN);
  assign advance  = pc_valid & fetch_ready;
  assign ras_top  = ras_mem[ras_ptr];

  // State register: BOOT lasts exactly one edge, TRAP waits for trap_clear.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN:  if (advance && misaligned) state_next = ST_TRAP;
      ST_TRAP: if (trap_clear) state_next = ST_RUN;
      default: state_next = ST_BOOT;
    endcase
  end

  // Target selection in priority order jalr > jal > taken branch > pc+4,
  // plus alignment check on redirected targets only.
  always_comb begin
    jalr_sum   = rs1_val + imm;
    rel_tgt    = pc + imm;
    take       = jalr | jal | (branch & alu_zero);
    tgt        = pc_plus4;
    if (jalr)                           tgt = {jalr_sum[XLEN-1:1], 1'b0};
    else if (jal || (branch && alu_zero)) tgt = rel_tgt;
    misaligned = take & (tgt[1:0] != 2'b00);
  end

  // RAS control: only aligned advances touch the stack; a misaligned
  // advance flushes it instead.
  always_comb begin
    do_push  = advance & ~misaligned & is_call & (jal | jalr);
    do_pop   = advance & ~misaligned & is_ret & jalr;
    pop_miss = do_pop & ((ras_count == '0) | (ras_top != tgt));
    ptr_next = ras_ptr;
    cnt_next = ras_count;
    if (advance && misaligned) begin
      cnt_next = '0;
    end else if (do_push && do_pop) begin
      // Coroutine swap: top entry replaced in place, depth unchanged.
      ptr_next = ras_ptr;
    end else if (do_push) begin
      ptr_next = ras_ptr + PTR_W'(1);
      if (ras_count != RAS_FULL) cnt_next = ras_count + CNT_W'(1);
    end else if (do_pop && (ras_count != '0)) begin
      ptr_next = ras_ptr - PTR_W'(1);
      cnt_next = ras_count - CNT_W'(1);
    end
  end

  // PC, trap/mispredict pulses and RAS bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_VEC;
      misalign_trap  <= 1'b0;
      ras_mispredict <= 1'b0;
      ras_ptr        <= '0;
      ras_count      <= '0;
    end else begin
      misalign_trap  <= advance & misaligned;
      ras_mispredict <= pop_miss;
      ras_ptr        <= ptr_next;
      ras_count      <= cnt_next;
      if (state == ST_TRAP)  pc <= TRAP_VEC;
      else if (advance)      pc <= misaligned ? TRAP_VEC : tgt;
    end
  end

  // RAS storage; on a push the new top lands at ptr_next (in place for a coroutine).
  // NOTE: the storage array has no reset; ras_count gates its validity, so
  // stale contents are harmless and the array can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[ptr_next] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed self-checking bench for pc_gen_unit with default parameters
// (XLEN=32, RESET_VEC=0, TRAP_VEC=0x100, RAS_DEPTH=4).
module tb_pc_gen_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] pc_plus4;
  logic [31:0] imm;
  logic [31:0] rs1_val;
  logic        branch;
  logic        alu_zero;
  logic        jal;
  logic        jalr;
  logic        is_call;
  logic        is_ret;
  logic        trap_clear;
  logic        misalign_trap;
  logic        ras_mispredict;
  logic [2:0]  ras_count;

  int checks = 0;
  int errors = 0;

  pc_gen_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_ready    (fetch_ready),
    .pc             (pc),
    .pc_valid       (pc_valid),
    .pc_plus4       (pc_plus4),
    .imm            (imm),
    .rs1_val        (rs1_val),
    .branch         (branch),
    .alu_zero       (alu_zero),
    .jal            (jal),
    .jalr           (jalr),
    .is_call        (is_call),
    .is_ret         (is_ret),
    .trap_clear     (trap_clear),
    .misalign_trap  (misalign_trap),
    .ras_mispredict (ras_mispredict),
    .ras_count      (ras_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled and inputs changed 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    fetch_ready = 1'b0;
    imm         = '0;
    rs1_val     = '0;
    branch      = 1'b0;
    alu_zero    = 1'b0;
    jal         = 1'b0;
    jalr        = 1'b0;
    is_call     = 1'b0;
    is_ret      = 1'b0;
    trap_clear  = 1'b0;
  endtask

  // Leaves the DUT in BOOT just after an edge.
  task automatic do_reset();
    clear_ctrl();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_ctrl();
    rst_n = 1'b0;
    #2;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pc_valid); end
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b expected 0", misalign_trap); end
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b expected 0", ras_mispredict); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ras_count); end
    step();
    step();
    rst_n       = 1'b1;
    fetch_ready = 1'b1;
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", pc_valid); end
    step();
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL run_valid: got %b expected 1", pc_valid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL run_first_pc: got %h expected %h", pc, 32'h0); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc !== 32'(i * 4)) begin errors++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 32'(i * 4)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_ready = 1'b1;
    step();
    step();
    step();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_start: got %h expected %h", pc, 32'h8); end
    fetch_ready = 1'b0;
    jal         = 1'b1;
    imm         = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, pc, 32'h8); end
    end
    fetch_ready = 1'b1;
    step();
    checks++; if (pc !== 32'h48) begin errors++; $display("FAIL stall_release: got %h expected %h", pc, 32'h48); end
  endtask

  task automatic test_priority();
    do_reset();
    fetch_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL prio_start: got %h expected %h", pc, 32'h10); end
    branch   = 1'b1;
    alu_zero = 1'b1;
    jal      = 1'b1;
    jalr     = 1'b1;
    rs1_val  = 32'h201;
    imm      = 32'h0;
    step();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL prio_jalr: got %h expected %h", pc, 32'h200); end
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL prio_no_trap: got %b expected 0", misalign_trap); end
    do_reset();
    fetch_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    branch   = 1'b1;
    alu_zero = 1'b0;
    imm      = 32'h40;
    step();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL branch_not_taken: got %h expected %h", pc, 32'h14); end
    alu_zero = 1'b1;
    imm      = 32'hFFFF_FFF8;
    step();
    checks++; if (pc !== 32'h0C) begin errors++; $display("FAIL branch_taken_back: got %h expected %h", pc, 32'h0C); end
  endtask

  task automatic test_misalign();
    do_reset();
    fetch_ready = 1'b1;
    step();
    jal     = 1'b1;
    is_call = 1'b1;
    imm     = 32'h20;
    step();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL mis_call_pc: got %h expected %h", pc, 32'h20); end
    checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL mis_call_count: got %0d expected 1", ras_count); end
    imm = 32'h6;
    step();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_trap_pc: got %h expected %h", pc, 32'h100); end
    checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_trap_pulse: got %b expected 1", misalign_trap); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL mis_trap_valid: got %b expected 0", pc_valid); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL mis_flush: got %0d expected 0", ras_count); end
    clear_ctrl();
    fetch_ready = 1'b1;
    step();
    checks++; if (misalign_trap !== 1'b0) begin errors++; $display("FAIL mis_pulse_end: got %b expected 0", misalign_trap); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_trap_hold: got %h expected %h", pc, 32'h100); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL mis_trap_wait: got %b expected 0", pc_valid); end
    trap_clear = 1'b1;
    step();
    trap_clear = 1'b0;
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL mis_clear_valid: got %b expected 1", pc_valid); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_clear_pc: got %h expected %h", pc, 32'h100); end
    step();
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL mis_resume: got %h expected %h", pc, 32'h104); end
    jalr    = 1'b1;
    rs1_val = 32'h203;
    step();
    checks++; if (misalign_trap !== 1'b1) begin errors++; $display("FAIL mis_jalr_bit1: got %b expected 1", misalign_trap); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL mis_jalr_pc: got %h expected %h", pc, 32'h100); end
  endtask

  task automatic test_ras();
    logic [31:0] rets [4];
    rets[0] = 32'h404;
    rets[1] = 32'h304;
    rets[2] = 32'h204;
    rets[3] = 32'h104;
    do_reset();
    fetch_ready = 1'b1;
    step();
    jal     = 1'b1;
    is_call = 1'b1;
    imm     = 32'h100;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (pc !== 32'((i + 1) * 32'h100)) begin errors++; $display("FAIL ras_call_pc[%0d]: got %h expected %h", i, pc, 32'((i + 1) * 32'h100)); end
      checks++; if (ras_count !== 3'((i < 4) ? i + 1 : 4)) begin errors++; $display("FAIL ras_call_count[%0d]: got %0d expected %0d", i, ras_count, (i < 4) ? i + 1 : 4); end
    end
    jal     = 1'b0;
    is_call = 1'b0;
    jalr    = 1'b1;
    is_ret  = 1'b1;
    imm     = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rs1_val = rets[i];
      step();
      checks++; if (pc !== rets[i]) begin errors++; $display("FAIL ras_ret_pc[%0d]: got %h expected %h", i, pc, rets[i]); end
      checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL ras_ret_hit[%0d]: got %b expected 0", i, ras_mispredict); end
      checks++; if (ras_count !== 3'(3 - i)) begin errors++; $display("FAIL ras_ret_count[%0d]: got %0d expected %0d", i, ras_count, 3 - i); end
    end
    rs1_val = 32'h200;
    step();
    checks++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL ras_empty_miss: got %b expected 1", ras_mispredict); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL ras_empty_floor: got %0d expected 0", ras_count); end
    clear_ctrl();
    fetch_ready = 1'b1;
    step();
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL ras_miss_pulse_end: got %b expected 0", ras_mispredict); end
  endtask

  task automatic test_wrap_coroutine();
    do_reset();
    fetch_ready = 1'b1;
    step();
    jal = 1'b1;
    imm = 32'hFFFF_FFFC;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_back: got %h expected %h", pc, 32'hFFFF_FFFC); end
    checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got %h expected %h", pc_plus4, 32'h0); end
    clear_ctrl();
    fetch_ready = 1'b1;
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_seq: got %h expected %h", pc, 32'h0); end
    is_call = 1'b1;
    step();
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL call_no_jump: got %0d expected 0", ras_count); end
    jal = 1'b1;
    imm = 32'h40;
    step();
    checks++; if (pc !== 32'h44 || ras_count !== 3'd1) begin errors++; $display("FAIL co_call: got pc=%h cnt=%0d expected pc=%h cnt=1", pc, ras_count, 32'h44); end
    jal     = 1'b0;
    jalr    = 1'b1;
    is_ret  = 1'b1;
    rs1_val = 32'h8;
    imm     = 32'h0;
    step();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL co_swap_pc: got %h expected %h", pc, 32'h8); end
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL co_swap_hit: got %b expected 0", ras_mispredict); end
    checks++; if (ras_count !== 3'd1) begin errors++; $display("FAIL co_swap_count: got %0d expected 1", ras_count); end
    is_call = 1'b0;
    rs1_val = 32'h48;
    step();
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL co_new_top: got %b expected 0", ras_mispredict); end
    checks++; if (ras_count !== 3'd0) begin errors++; $display("FAIL co_pop_count: got %0d expected 0", ras_count); end
    jalr    = 1'b0;
    is_ret  = 1'b0;
    jal     = 1'b1;
    is_call = 1'b1;
    imm     = 32'h10;
    step();
    jal     = 1'b0;
    is_call = 1'b0;
    jalr    = 1'b1;
    is_ret  = 1'b1;
    rs1_val = 32'h50;
    imm     = 32'h0;
    step();
    checks++; if (ras_mispredict !== 1'b1) begin errors++; $display("FAIL ret_wrong_target: got %b expected 1", ras_mispredict); end
    checks++; if (pc !== 32'h50) begin errors++; $display("FAIL ret_wrong_pc: got %h expected %h", pc, 32'h50); end
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL async_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL async_mispredict: got %b expected 0", ras_mispredict); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b expected 0", pc_valid); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_priority();
    test_misalign();
    test_ras();
    test_wrap_coroutine();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
